i_wr_addr_gen: RTL

I_WR_ADDR_GEN -- requirements
Module: i_wr_addr_gen

---
 rtl/i_wr_addr_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/i_wr_addr_gen.sv
// Raster-order SRAM write address generator.
// Walks col/row over a latched W x H frame and produces the matching SRAM
// address. The row-start address is advanced by row_stride on every row wrap,
// so no multiplier is needed. All outputs are registered.
module i_wr_addr_gen #(
    parameter int unsigned DIM_W    = 13,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned PX_BYTES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic              step,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              eol,
    output logic              eof,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [DIM_W-1:0]  cfg_w, cfg_w_n, cfg_h, cfg_h_n;
    logic [ADDR_W-1:0] cfg_base, cfg_base_n, cfg_stride, cfg_stride_n;
    logic [ADDR_W-1:0] row_start, row_start_n;
    logic [DIM_W-1:0]  col_n, row_n;
    logic [ADDR_W-1:0] addr_n;
    logic              busy_n, eol_n, eof_n, cfg_err_n;
    logic              cfg_ok;

    assign cfg_ok = (img_width != '0) && (img_height != '0);

    // State and output registers; async reset clears everything including config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cfg_w      <= '0;
            cfg_h      <= '0;
            cfg_base   <= '0;
            cfg_stride <= '0;
            row_start  <= '0;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            busy       <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cfg_w      <= cfg_w_n;
            cfg_h      <= cfg_h_n;
            cfg_base   <= cfg_base_n;
            cfg_stride <= cfg_stride_n;
            row_start  <= row_start_n;
            col        <= col_n;
            row        <= row_n;
            addr       <= addr_n;
            busy       <= busy_n;
            eol        <= eol_n;
            eof        <= eof_n;
            cfg_err    <= cfg_err_n;
        end
    end

    // Next-state and next-output logic; priority is clear > start > step.
    always_comb begin
        state_n      = state;
        cfg_w_n      = cfg_w;
        cfg_h_n      = cfg_h;
        cfg_base_n   = cfg_base;
        cfg_stride_n = cfg_stride;
        row_start_n  = row_start;
        col_n        = col;
        row_n        = row;
        addr_n       = addr;
        eol_n        = eol;
        eof_n        = eof;
        cfg_err_n    = 1'b0;

        if (clear) begin
            state_n     = IDLE;
            row_start_n = '0;
            col_n       = '0;
            row_n       = '0;
            addr_n      = '0;
            eol_n       = 1'b0;
            eof_n       = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state_n      = RUN;
                            cfg_w_n      = img_width;
                            cfg_h_n      = img_height;
                            cfg_base_n   = base_addr;
                            cfg_stride_n = row_stride;
                            row_start_n  = base_addr;
                            col_n        = '0;
                            row_n        = '0;
                            addr_n       = base_addr;
                            eol_n        = 1'b0;
                            eof_n        = 1'b0;
                        end else begin
                            cfg_err_n = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (step) begin
                        if (col != cfg_w - DIM_W'(1)) begin
                            col_n  = col + DIM_W'(1);
                            addr_n = addr + ADDR_W'(PX_BYTES);
                            eol_n  = 1'b0;
                        end else if (row != cfg_h - DIM_W'(1)) begin
                            col_n       = '0;
                            row_n       = row + DIM_W'(1);
                            row_start_n = row_start + cfg_stride;
                            addr_n      = row_start + cfg_stride;
                            eol_n       = 1'b1;
                        end else begin
                            state_n     = DONE;
                            col_n       = '0;
                            row_n       = '0;
                            row_start_n = cfg_base;
                            addr_n      = cfg_base;
                            eol_n       = 1'b1;
                            eof_n       = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n == RUN);
    end

endmodule
